anton_neopixel_stream_sequencer: RTL
====================================

// Module: anton_neopixel_stream_sequencer
// PURPOSE
//  Timing/sequencing core of the NeoPixel controller, parametrised successor of the stream logic.
//  Walks sub-bit pattern steps, pixel bits and pixel indices, then holds the line in reset (latch) delay.
//  Adds IDLE state, one-shot vs loop framing, RGB(24b)/RGBW(32b) pixels, pause/resume, frame-config latching.
//  Sits between the APB register file and the pattern/output serialiser; no simulation $finish inside.
// PARAMETERS
//  BUFFER_END     `BUFFER_END_DEFAULT   last valid byte address of the pixel buffer
//  RESET_DELAY    `RESET_DELAY_DEFAULT  clk ticks held in RESET before frame ends
//  PATTERN_STEPS  8                     sub-bit steps per bit, must be a power of 2 (>=2)
//  BUFFER_BITS    `CLOG2(BUFFER_END+1)  localparam; RD_BITS=`CLOG2(RESET_DELAY+1), PS_BITS=`CLOG2(PATTERN_STEPS)
// PORTS
//  clk6_4mhz      in   1            stream clock (6.4MHz)
//  rst            in   1            asynchronous, active-high reset
//  regCtrlInit    in   1            hold: freezes all counters, stream outputs low
//  regCtrlRun     in   1            run enable; low mid-frame = pause (counters hold)
//  regCtrlLoop    in   1            1 = free-running frames, 0 = one frame per Run rising edge
//  regCtrlLimit   in   1            1 = stop at regMax, 0 = stop at BUFFER_END
//  regCtrl32bit   in   1            32bit addressing: pixelIndex steps by 4
//  regCtrlRgbw    in   1            1 = 32 bits/pixel, 0 = 24 bits/pixel
//  regMax         in   13           software pixel limit (low BUFFER_BITS used)
//  initSlow       in   1            request: clear indices and return to IDLE
//  initSlowDone   out  1            one-cycle ack of initSlow
//  bitPatternIndex out PS_BITS      sub-bit step
//  pixelBitIndex  out  5            bit within pixel, 0..23 or 0..31
//  pixelIndex     out  BUFFER_BITS  current buffer address
//  pixelIndexMax  out  BUFFER_BITS  latched frame end address
//  state          out  2            `ENUM_STATE_IDLE / _TRANSMIT / _RESET
//  streamOutput   out  1            transmitting this cycle
//  streamReset    out  1            reset delay counting this cycle
//  streamBitOf / streamPixelOf / streamSyncOf  out 1 each  pixel-done / frame-data-done / reset-delay-done strobes
//  frameDone      out  1            one-cycle pulse when a frame (data + reset) completes
// BEHAVIOUR
//  Reset (async): all counters 0, state IDLE, latched config 0 (RGB, 8bit, max=BUFFER_END), all outputs 0.
//  active = Run && !Init. streamOutput = active && TRANSMIT; streamReset = active && RESET.
//  IDLE->TRANSMIT: loop: active; one-shot: active && Run rose (registered runPrev). Same edge latches
//    rgbw, 32bit, pixelIndexMax = Limit ? regMax[BUFFER_BITS-1:0] : BUFFER_END; held until next frame start.
//  TRANSMIT: bitPatternIndex +1 per streamOutput cycle, wraps PATTERN_STEPS-1 -> 0 (patternOf).
//    patternOf: pixelBitIndex +1; at last bit (23|31 per latched rgbw) -> 0 and streamBitOf.
//    idxEq = 32bit ? {pixelIndex[BUFFER_BITS-1:2],2'b11} : pixelIndex; last = idxEq >= pixelIndexMax.
//    streamBitOf && !last: pixelIndex += 32bit ? 4 : 1; && last: pixelIndex<=0, streamPixelOf, ->RESET.
//  RESET: resetDelayCount +1 per streamReset cycle; streamSyncOf = (count==RESET_DELAY) && active;
//    on sync: count<=0, frameDone pulse, ->TRANSMIT (loop, relatching config) else ->IDLE. Total RESET_DELAY+1 cycles.
//  Pause (Run low or Init high) freezes every counter/state; resumes exactly where held, no glitch strobes.
//  initSlow: next edge clears pixelIndex, pixelBitIndex, bitPatternIndex, resetDelayCount, state=IDLE;
//    initSlowDone=1 for exactly one cycle after; initSlow wins over any simultaneous strobe/transition.
//  regMax > BUFFER_END: clamped to BUFFER_END when latched. Config changes mid-frame have no effect.
// STRUCTURE
//  anton_common.vh: add `ENUM_STATE_IDLE (2'd0), widen _TRANSMIT(2'd1)/_RESET(2'd2), `PIXEL_BITS_RGB/RGBW (24/32).
//  Sub-module anton_neopixel_reset_timer (RD_BITS counter, enable/clear, sync strobe); rest inline.
// TESTING  (BUFFER_END=7, RESET_DELAY=20, PATTERN_STEPS=8)
//  Loop, RGB, 8bit, no limit: Run=1 -> 8 px x 24 bit x 8 steps = 1536 TRANSMIT cycles, 21 RESET, frameDone, repeats.
//  One-shot, RGBW, Limit regMax=2: 3 px x 32 bits; then IDLE; holding Run high starts nothing; Run 0->1 restarts.
//  32bit mode, max 7: pixelIndex 0,4 only; streamPixelOf when idxEq=7; pixelIndex back to 0.
//  Drop Run at pixel 3 bit 10 step 5 for 50 cycles: all counters frozen, outputs low, resume identical.
//  initSlow coincident with streamBitOf: indices 0, state IDLE, initSlowDone one cycle; rst mid-RESET clears at once.
//  regCtrlRgbw/regMax toggled mid-frame: current frame unaffected; new values take effect next frame.

Source files
------------

// File: rtl/anton_neopixel_stream_sequencer_pkg.sv
// Shared types and constants for the NeoPixel stream sequencer.
package anton_neopixel_stream_sequencer_pkg;

    localparam int BUFFER_END_DEFAULT  = 2047;
    localparam int RESET_DELAY_DEFAULT = 320;   // 50 us of latch time at 6.4 MHz
    localparam int PIXEL_BITS_RGB      = 24;
    localparam int PIXEL_BITS_RGBW     = 32;

    typedef enum logic [1:0] {
        STATE_IDLE     = 2'd0,
        STATE_TRANSMIT = 2'd1,
        STATE_RESET    = 2'd2
    } seqState_t;

    // Pixel format captured at frame start and held for the whole frame.
    typedef struct packed {
        logic rgbw;
        logic addr32;
    } frameCfg_t;

    // Index of the final bit of a pixel for the given format.
    function automatic logic [4:0] lastPixelBit(input logic rgbw);
        return rgbw ? 5'(PIXEL_BITS_RGBW - 1) : 5'(PIXEL_BITS_RGB - 1);
    endfunction

endpackage

// File: rtl/anton_neopixel_stream_sequencer_if.sv
// Register-file / serialiser side of the sequencer, grouped as one bundle.
interface anton_neopixel_stream_sequencer_if
    import anton_neopixel_stream_sequencer_pkg::*;
#(
    parameter int BUFFER_END    = BUFFER_END_DEFAULT,
    parameter int PATTERN_STEPS = 8
);
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
    localparam int PS_BITS     = $clog2(PATTERN_STEPS);

    logic                   regCtrlInit;
    logic                   regCtrlRun;
    logic                   regCtrlLoop;
    logic                   regCtrlLimit;
    logic                   regCtrl32bit;
    logic                   regCtrlRgbw;
    logic [12:0]            regMax;
    logic                   initSlow;
    logic                   initSlowDone;
    logic [PS_BITS-1:0]     bitPatternIndex;
    logic [4:0]             pixelBitIndex;
    logic [BUFFER_BITS-1:0] pixelIndex;
    logic [BUFFER_BITS-1:0] pixelIndexMax;
    logic [1:0]             state;
    logic                   streamOutput;
    logic                   streamReset;
    logic                   streamBitOf;
    logic                   streamPixelOf;
    logic                   streamSyncOf;
    logic                   frameDone;

    modport master (
        output regCtrlInit, regCtrlRun, regCtrlLoop, regCtrlLimit, regCtrl32bit,
               regCtrlRgbw, regMax, initSlow,
        input  initSlowDone, bitPatternIndex, pixelBitIndex, pixelIndex, pixelIndexMax,
               state, streamOutput, streamReset, streamBitOf, streamPixelOf,
               streamSyncOf, frameDone
    );

    modport slave (
        input  regCtrlInit, regCtrlRun, regCtrlLoop, regCtrlLimit, regCtrl32bit,
               regCtrlRgbw, regMax, initSlow,
        output initSlowDone, bitPatternIndex, pixelBitIndex, pixelIndex, pixelIndexMax,
               state, streamOutput, streamReset, streamBitOf, streamPixelOf,
               streamSyncOf, frameDone
    );
endinterface

// File: rtl/anton_neopixel_reset_timer.sv
// Latch (reset) delay counter: counts enabled cycles, strobes sync on the last one.
module anton_neopixel_reset_timer #(
    parameter int RESET_DELAY = 320
) (
    input  logic clk6_4mhz,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sync
);
    localparam int RD_BITS = $clog2(RESET_DELAY + 1);

    logic [RD_BITS-1:0] resetDelayCount;

    // A clear request suppresses the strobe so it cannot end a frame being aborted.
    assign sync = en && !clr && (resetDelayCount == RD_BITS'(RESET_DELAY));

    // Count while enabled, wrap to zero on sync, hold otherwise.
    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst)
            resetDelayCount <= '0;
        else if (clr || sync)
            resetDelayCount <= '0;
        else if (en)
            resetDelayCount <= resetDelayCount + RD_BITS'(1);
    end
endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// NeoPixel stream sequencer: walks pattern steps, pixel bits and pixel addresses,
// then holds the line low for the latch delay. Supports one-shot/loop framing,
// RGB/RGBW pixels, pause/resume and per-frame configuration latching.
module anton_neopixel_stream_sequencer
    import anton_neopixel_stream_sequencer_pkg::*;
#(
    parameter int BUFFER_END    = BUFFER_END_DEFAULT,
    parameter int RESET_DELAY   = RESET_DELAY_DEFAULT,
    parameter int PATTERN_STEPS = 8
) (
    input logic clk6_4mhz,
    input logic rst,
    anton_neopixel_stream_sequencer_if.slave bus
);
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
    localparam int PS_BITS     = $clog2(PATTERN_STEPS);

    seqState_t              state;
    frameCfg_t              cfg;
    logic                   runPrev;
    logic [PS_BITS-1:0]     bitPatternIndex;
    logic [4:0]             pixelBitIndex;
    logic [BUFFER_BITS-1:0] pixelIndex;
    logic [BUFFER_BITS-1:0] pixelIndexMax;
    logic [BUFFER_BITS-1:0] maxNext;
    logic [BUFFER_BITS-1:0] idxEq;
    logic                   initSlowDone;
    logic                   frameDone;
    logic                   active, startOk, patternOf, lastBit, last;
    logic                   streamOutput, streamReset, streamBitOf, streamPixelOf, streamSyncOf;

    assign active       = bus.regCtrlRun && !bus.regCtrlInit;
    assign streamOutput = active && (state == STATE_TRANSMIT);
    assign streamReset  = active && (state == STATE_RESET);
    // Loop mode starts whenever active; one-shot needs a fresh Run rising edge.
    assign startOk      = active && (bus.regCtrlLoop || !runPrev);

    // Frame end address; an oversized software limit saturates at the buffer end.
    assign maxNext = !bus.regCtrlLimit                 ? BUFFER_BITS'(BUFFER_END) :
                     (bus.regMax > 13'(BUFFER_END))    ? BUFFER_BITS'(BUFFER_END) :
                                                         bus.regMax[BUFFER_BITS-1:0];

    // In 32-bit addressing a pixel spans four bytes, so compare its last byte.
    assign idxEq     = cfg.addr32 ? {pixelIndex[BUFFER_BITS-1:2], 2'b11} : pixelIndex;
    assign last      = idxEq >= pixelIndexMax;
    assign patternOf = bitPatternIndex == PS_BITS'(PATTERN_STEPS - 1);
    assign lastBit   = pixelBitIndex == lastPixelBit(cfg.rgbw);

    // initSlow overrides everything, so strobes are masked in its cycle.
    assign streamBitOf   = streamOutput && patternOf && lastBit && !bus.initSlow;
    assign streamPixelOf = streamBitOf && last;

    anton_neopixel_reset_timer #(.RESET_DELAY(RESET_DELAY)) uResetTimer (
        .clk6_4mhz (clk6_4mhz),
        .rst       (rst),
        .en        (streamReset),
        .clr       (bus.initSlow),
        .sync      (streamSyncOf)
    );

    // Sequencer FSM: counters advance only on active cycles, so a pause freezes everything.
    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            state           <= STATE_IDLE;
            cfg             <= '0;
            runPrev         <= 1'b0;
            bitPatternIndex <= '0;
            pixelBitIndex   <= '0;
            pixelIndex      <= '0;
            pixelIndexMax   <= BUFFER_BITS'(BUFFER_END);
            initSlowDone    <= 1'b0;
            frameDone       <= 1'b0;
        end else begin
            runPrev      <= bus.regCtrlRun;
            initSlowDone <= bus.initSlow;
            frameDone    <= 1'b0;
            if (bus.initSlow) begin
                state           <= STATE_IDLE;
                bitPatternIndex <= '0;
                pixelBitIndex   <= '0;
                pixelIndex      <= '0;
            end else begin
                case (state)
                    STATE_IDLE: begin
                        if (startOk) begin
                            state         <= STATE_TRANSMIT;
                            cfg           <= '{rgbw: bus.regCtrlRgbw, addr32: bus.regCtrl32bit};
                            pixelIndexMax <= maxNext;
                        end
                    end
                    STATE_TRANSMIT: begin
                        if (streamOutput) begin
                            bitPatternIndex <= bitPatternIndex + PS_BITS'(1);
                            if (patternOf) begin
                                if (lastBit) begin
                                    pixelBitIndex <= '0;
                                    if (last) begin
                                        pixelIndex <= '0;
                                        state      <= STATE_RESET;
                                    end else begin
                                        pixelIndex <= pixelIndex +
                                            (cfg.addr32 ? BUFFER_BITS'(4) : BUFFER_BITS'(1));
                                    end
                                end else begin
                                    pixelBitIndex <= pixelBitIndex + 5'd1;
                                end
                            end
                        end
                    end
                    STATE_RESET: begin
                        if (streamSyncOf) begin
                            frameDone <= 1'b1;
                            if (bus.regCtrlLoop) begin
                                state         <= STATE_TRANSMIT;
                                cfg           <= '{rgbw: bus.regCtrlRgbw, addr32: bus.regCtrl32bit};
                                pixelIndexMax <= maxNext;
                            end else begin
                                state <= STATE_IDLE;
                            end
                        end
                    end
                    default: state <= STATE_IDLE;
                endcase
            end
        end
    end

    assign bus.state           = state;
    assign bus.bitPatternIndex = bitPatternIndex;
    assign bus.pixelBitIndex   = pixelBitIndex;
    assign bus.pixelIndex      = pixelIndex;
    assign bus.pixelIndexMax   = pixelIndexMax;
    assign bus.streamOutput    = streamOutput;
    assign bus.streamReset     = streamReset;
    assign bus.streamBitOf     = streamBitOf;
    assign bus.streamPixelOf   = streamPixelOf;
    assign bus.streamSyncOf    = streamSyncOf;
    assign bus.initSlowDone    = initSlowDone;
    assign bus.frameDone       = frameDone;
endmodule
